// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, width helpers
// and SPI mode constants.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD
   } spi_state_e;

   localparam logic CPOL_IDLE_LOW  = 1'b0;
   localparam logic CPOL_IDLE_HIGH = 1'b1;
   localparam logic CPHA_LEADING   = 1'b0;
   localparam logic CPHA_TRAILING  = 1'b1;

   // Width of a select index for n slaves; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Edge counter width: one extra bit so 2*n edges fit without wrapping.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI master: counts 0..CLK_DIV-1 while enabled,
// synchronous clear, tick on the last count.
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic global_clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned      CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise wrap at the last count while enabled.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   assign tick = en && (count_q == LAST);

   // Counter register.
   always_ff @(posedge global_clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one full-duplex DATA_W-bit transfer per accepted start.
// Optional internal loopback is enabled by defining SPI_MASTER_LOOPBACK_EN.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned NUM_SS    = 1,
   parameter bit          CPOL      = 1'b0,
   parameter bit          CPHA      = 1'b0,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned SEL_W     = sel_width(NUM_SS)
) (
   input  logic              global_clk,
   input  logic              reset,
   input  logic              get_data,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [SEL_W-1:0]  ss_sel,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic [NUM_SS-1:0] ss
);

   localparam int unsigned       EDGE_W    = cnt_width(DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
   localparam logic              SCLK_IDLE = CPOL ? CPOL_IDLE_HIGH : CPOL_IDLE_LOW;

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic [NUM_SS-1:0] ss_q, ss_d, ss_dec;
   logic              tick, start, lead_edge, last_edge;
   logic              sample_now, shift_now, sample_bit, lb_start;

`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb_q, lb_d;
   assign lb_start   = loopback;
   assign sample_bit = lb_q ? mosi_q : miso;
`else
   assign lb_start   = 1'b0;
   assign sample_bit = miso;
`endif

   // A start in the done cycle is refused so a new transfer begins one cycle later.
   assign start     = (state_q == ST_IDLE) && get_data && !done_q;
   // Even-numbered edges move sclk away from its idle level.
   assign lead_edge = ~edge_q[0];
   assign last_edge = (edge_q == LAST_EDGE);
   assign sample_now = (CPHA == CPHA_LEADING) ? lead_edge : ~lead_edge;
   // The first bit is already on mosi at start, so only DATA_W-1 shifts follow.
   assign shift_now  = (CPHA == CPHA_TRAILING) ? (lead_edge && (edge_q != '0))
                                               : (~lead_edge && ~last_edge);

   spi_clk_div #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_div (
      .global_clk(global_clk),
      .reset     (reset),
      .en        (state_q != ST_IDLE),
      .clr       (start),
      .tick      (tick)
   );

   // Decode the requested slave; out-of-range or loopback leaves all selects high.
   always_comb begin
      ss_dec = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         if (!lb_start && (32'(ss_sel) == i)) ss_dec[i] = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge global_clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: each phase advances on a divider tick.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start)              state_d = ST_SETUP;
         ST_SETUP: if (tick)               state_d = ST_XFER;
         ST_XFER:  if (tick && last_edge)  state_d = ST_HOLD;
         ST_HOLD:  if (tick)               state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values: load on start, shift/sample on edges, finish in HOLD.
   always_comb begin
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      edge_d    = edge_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_d      = ss_q;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_d      = lb_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               tx_sr_d = tx_data;
               rx_sr_d = '0;
               edge_d  = '0;
               busy_d  = 1'b1;
               ss_d    = ss_dec;
               mosi_d  = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
`ifdef SPI_MASTER_LOOPBACK_EN
               lb_d    = loopback;
`endif
            end
         end
         ST_SETUP: ;
         ST_XFER: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (!last_edge) edge_d = edge_q + 1'b1;
               if (sample_now) begin
                  rx_sr_d = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], sample_bit}
                                      : {sample_bit, rx_sr_q[DATA_W-1:1]};
               end
               if (shift_now) begin
                  tx_sr_d = MSB_FIRST ? (tx_sr_q << 1) : (tx_sr_q >> 1);
                  mosi_d  = MSB_FIRST ? tx_sr_q[DATA_W-2] : tx_sr_q[1];
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               busy_d    = 1'b0;
               done_d    = 1'b1;
               ss_d      = '1;
               rx_data_d = rx_sr_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge global_clk or negedge reset) begin
      if (!reset) begin
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         edge_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= SCLK_IDLE;
         mosi_q    <= 1'b0;
         ss_q      <= '1;
`ifdef SPI_MASTER_LOOPBACK_EN
         lb_q      <= 1'b0;
`endif
      end else begin
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         edge_q    <= edge_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_q      <= ss_d;
`ifdef SPI_MASTER_LOOPBACK_EN
         lb_q      <= lb_d;
`endif
      end
   end

   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign ss      = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (mode 0 MSB-first with 4 selects,
// mode 3 LSB-first with 1 select), behavioural slaves, scoreboard queues.
module tb_spi_master_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Instance 0: CPOL=0 CPHA=0 MSB first, NUM_SS=4, widened select.
   logic       get0 = 1'b0;
   logic [7:0] tx0  = '0;
   logic [2:0] sel0 = '0;
   logic [7:0] rx0;
   logic       busy0, done0, sclk0, mosi0, miso0;
   logic [3:0] ss0;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic       lb0 = 1'b0;
   logic       lb1 = 1'b0;
`endif

   spi_master_ctrl #(
      .DATA_W(8), .CLK_DIV(4), .NUM_SS(4), .CPOL(1'b0), .CPHA(1'b0),
      .MSB_FIRST(1'b1), .SEL_W(3)
   ) u0 (
      .global_clk(clk), .reset(rst_n), .get_data(get0), .tx_data(tx0),
      .ss_sel(sel0), .rx_data(rx0), .busy(busy0), .done(done0),
      .sclk(sclk0), .mosi(mosi0), .miso(miso0),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(lb0),
`endif
      .ss(ss0)
   );

   // Instance 1: CPOL=1 CPHA=1 LSB first, single select.
   logic       get1 = 1'b0;
   logic [7:0] tx1  = '0;
   logic [0:0] sel1 = '0;
   logic [7:0] rx1;
   logic       busy1, done1, sclk1, mosi1, miso1;
   logic [0:0] ss1;

   spi_master_ctrl #(
      .DATA_W(8), .CLK_DIV(4), .NUM_SS(1), .CPOL(1'b1), .CPHA(1'b1),
      .MSB_FIRST(1'b0)
   ) u1 (
      .global_clk(clk), .reset(rst_n), .get_data(get1), .tx_data(tx1),
      .ss_sel(sel1), .rx_data(rx1), .busy(busy1), .done(done1),
      .sclk(sclk1), .mosi(mosi1), .miso(miso1),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(lb1),
`endif
      .ss(ss1)
   );

   // Slave models: count sclk edges, capture mosi on the slave sample edge,
   // and present the slave word on miso in the matching order.
   logic [7:0]  slv0 = '0, slv1 = '0, cap0 = '0, cap1 = '0;
   int unsigned lead0 = 0, trail0 = 0, lead1 = 0, trail1 = 0;
   int unsigned lbase0 = 0, tbase0 = 0, lbase1 = 0, tbase1 = 0;

   always @(sclk0) begin
      if (sclk0 === 1'b1) begin
         lead0++;
         cap0 = {cap0[6:0], mosi0};
      end else if (sclk0 === 1'b0) begin
         trail0++;
      end
   end

   always @(sclk1) begin
      if (sclk1 === 1'b0) begin
         lead1++;
      end else if (sclk1 === 1'b1) begin
         trail1++;
         cap1 = {mosi1, cap1[7:1]};
      end
   end

   always_comb miso0 = ((trail0 - tbase0) < 8) ? slv0[3'(7 - (trail0 - tbase0))] : 1'b0;
   always_comb miso1 = slv1[3'(((lead1 - lbase1) == 0) ? 0 : (lead1 - lbase1 - 1))];

   logic [7:0] q_rx0[$], q_tx0[$], q_rx1[$], q_tx1[$];

   task automatic start0(input logic [7:0] tx, input logic [7:0] slv,
                         input logic [2:0] sel, input logic [7:0] exp_rx);
      @(posedge clk);
      @(negedge clk);
      slv0 = slv; tbase0 = trail0; lbase0 = lead0;
      tx0 = tx; sel0 = sel; get0 = 1'b1;
      q_rx0.push_back(exp_rx);
      q_tx0.push_back(tx);
      @(negedge clk);
      get0 = 1'b0;
   endtask

   // Waits for done on u0, pops the scoreboard and checks the transfer.
   task automatic wait_done0(input logic [3:0] exp_ss, input int unsigned poke_at,
                             input string name);
      int unsigned n = 0;
      bit          seen = 1'b0;
      logic [3:0]  s_and = '1, s_or = '0;
      logic [7:0]  er, et;
      while (n < 200 && !seen) begin
         @(posedge clk); n++; #1;
         if (done0) seen = 1'b1;
         else if (busy0) begin s_and &= ss0; s_or |= ss0; end
         if (poke_at != 0 && n == poke_at) begin get0 = 1'b1; tx0 = 8'hFF; sel0 = 3'd1; end
         else if (poke_at != 0) get0 = 1'b0;
      end
      get0 = 1'b0;
      er = q_rx0.pop_front();
      et = q_tx0.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: done not seen after %0d cycles, required within 200", name, n);
      end else begin
         checks++;
         if (n !== 72) begin errors++; $display("FAIL %s_latency: got %0d cycles, expected 72", name, n); end
         checks++;
         if (rx0 !== er) begin errors++; $display("FAIL %s_rx: got %h, expected %h", name, rx0, er); end
         checks++;
         if (cap0 !== et) begin errors++; $display("FAIL %s_mosi: got %h, expected %h", name, cap0, et); end
         checks++;
         if ((lead0 - lbase0) !== 8) begin errors++; $display("FAIL %s_edges: got %0d leading, expected 8", name, lead0 - lbase0); end
         checks++;
         if (s_and !== exp_ss || s_or !== exp_ss) begin
            errors++; $display("FAIL %s_ss: got and=%b or=%b, expected %b", name, s_and, s_or, exp_ss);
         end
         checks++;
         if (busy0 !== 1'b0 || ss0 !== 4'hF || sclk0 !== 1'b0) begin
            errors++; $display("FAIL %s_end: got busy=%b ss=%b sclk=%b, expected 0 1111 0", name, busy0, ss0, sclk0);
         end
      end
   endtask

   task automatic xfer1(input logic [7:0] tx, input logic [7:0] slv, input string name);
      int unsigned n = 0;
      bit          seen = 1'b0;
      logic        s_or = 1'b0, idle_ok = 1'b1;
      logic [7:0]  er, et;
      @(posedge clk);
      @(negedge clk);
      if (sclk1 !== 1'b1) idle_ok = 1'b0;
      slv1 = slv; tbase1 = trail1; lbase1 = lead1;
      tx1 = tx; get1 = 1'b1;
      q_rx1.push_back(slv);
      q_tx1.push_back(tx);
      @(negedge clk);
      get1 = 1'b0;
      while (n < 200 && !seen) begin
         @(posedge clk); n++; #1;
         if (done1) seen = 1'b1;
         else if (busy1) s_or |= ss1[0];
      end
      er = q_rx1.pop_front();
      et = q_tx1.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: done not seen after %0d cycles, required within 200", name, n);
      end else begin
         checks++;
         if (n !== 72) begin errors++; $display("FAIL %s_latency: got %0d cycles, expected 72", name, n); end
         checks++;
         if (rx1 !== er) begin errors++; $display("FAIL %s_rx: got %h, expected %h", name, rx1, er); end
         checks++;
         if (cap1 !== et) begin errors++; $display("FAIL %s_mosi: got %h, expected %h", name, cap1, et); end
         checks++;
         if ((lead1 - lbase1) !== 8) begin errors++; $display("FAIL %s_edges: got %0d leading, expected 8", name, lead1 - lbase1); end
         checks++;
         if (s_or !== 1'b0 || ss1 !== 1'b1) begin errors++; $display("FAIL %s_ss: got during=%b after=%b, expected 0 1", name, s_or, ss1); end
         checks++;
         if (!idle_ok || sclk1 !== 1'b1) begin errors++; $display("FAIL %s_idle: got sclk=%b, expected 1", name, sclk1); end
      end
   endtask

   task automatic test_reset;
      #22;
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || rx0 !== 8'h00) begin
         errors++; $display("FAIL reset_u0_ctrl: got busy=%b done=%b rx=%h, expected 0 0 00", busy0, done0, rx0);
      end
      checks++;
      if (sclk0 !== 1'b0 || mosi0 !== 1'b0 || ss0 !== 4'hF) begin
         errors++; $display("FAIL reset_u0_pins: got sclk=%b mosi=%b ss=%b, expected 0 0 1111", sclk0, mosi0, ss0);
      end
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || rx1 !== 8'h00 || sclk1 !== 1'b1 || mosi1 !== 1'b0 || ss1 !== 1'b1) begin
         errors++; $display("FAIL reset_u1: got busy=%b done=%b rx=%h sclk=%b mosi=%b ss=%b, expected 0 0 00 1 0 1",
                            busy1, done1, rx1, sclk1, mosi1, ss1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mode0;
      start0(8'hA5, 8'h3C, 3'd0, 8'h3C);
      wait_done0(4'b1110, 0, "mode0_a5");
      start0(8'h96, 8'hE1, 3'd0, 8'hE1);
      wait_done0(4'b1110, 0, "mode0_96");
   endtask

   task automatic test_mode3;
      xfer1(8'h81, 8'h7E, "mode3_81");
      xfer1(8'h3C, 8'hA6, "mode3_3c");
   endtask

   task automatic test_ss_select;
      start0(8'h5A, 8'h0F, 3'd2, 8'h0F);
      wait_done0(4'b1011, 0, "sel2");
      start0(8'hC9, 8'h71, 3'd5, 8'h71);
      wait_done0(4'b1111, 0, "sel5");
      start0(8'h12, 8'hFE, 3'd3, 8'hFE);
      wait_done0(4'b0111, 0, "sel3");
   endtask

   task automatic test_ignore;
      int unsigned nb = 0, nd = 0, nc = 0;
      logic [7:0]  hold;
      start0(8'h6B, 8'h94, 3'd0, 8'h94);
      wait_done0(4'b1110, 10, "ignore");
      get0 = 1'b1; tx0 = 8'h11;
      @(posedge clk); #1;
      get0 = 1'b0;
      hold = rx0;
      repeat (100) begin
         @(posedge clk); #1;
         if (busy0) nb++;
         if (done0) nd++;
         if (rx0 !== hold) nc++;
      end
      checks++;
      if (nb !== 0 || nd !== 0) begin
         errors++; $display("FAIL ignore_done_cycle: got busy cycles=%0d extra done=%0d, expected 0 0", nb, nd);
      end
      checks++;
      if (nc !== 0) begin errors++; $display("FAIL ignore_rx_stable: got %0d changes, expected 0", nc); end
   endtask

   task automatic test_back_to_back;
      start0(8'h3E, 8'h5D, 3'd0, 8'h5D);
      wait_done0(4'b1110, 0, "b2b_first");
      slv0 = 8'hB4; tbase0 = trail0; lbase0 = lead0;
      tx0 = 8'h27; sel0 = 3'd1; get0 = 1'b1;
      q_rx0.push_back(8'hB4);
      q_tx0.push_back(8'h27);
      @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b0 || ss0 !== 4'hF) begin
         errors++; $display("FAIL b2b_gap: got busy=%b ss=%b, expected 0 1111", busy0, ss0);
      end
      @(posedge clk); #1;
      get0 = 1'b0;
      checks++;
      if (busy0 !== 1'b1 || ss0 !== 4'b1101 || mosi0 !== 1'b0) begin
         errors++; $display("FAIL b2b_start: got busy=%b ss=%b mosi=%b, expected 1 1101 0", busy0, ss0, mosi0);
      end
      wait_done0(4'b1101, 0, "b2b_second");
   endtask

   task automatic test_reset_mid;
      int unsigned nd = 0, nb = 0;
      @(posedge clk);
      @(negedge clk);
      tx0 = 8'hE7; sel0 = 3'd0; get0 = 1'b1; lbase0 = lead0;
      @(negedge clk);
      get0 = 1'b0;
      repeat (24) @(posedge clk);
      #2;
      checks++;
      if (busy0 !== 1'b1 || sclk0 !== 1'b1 || (lead0 - lbase0) !== 3) begin
         errors++; $display("FAIL midrst_pre: got busy=%b sclk=%b leading=%0d, expected 1 1 3", busy0, sclk0, lead0 - lbase0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || ss0 !== 4'hF || sclk0 !== 1'b0 || mosi0 !== 1'b0 || rx0 !== 8'h00) begin
         errors++; $display("FAIL midrst_outputs: got busy=%b done=%b ss=%b sclk=%b mosi=%b rx=%h, expected 0 0 1111 0 0 00",
                            busy0, done0, ss0, sclk0, mosi0, rx0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) begin
         @(posedge clk); #1;
         if (done0) nd++;
         if (busy0) nb++;
      end
      checks++;
      if (nd !== 0 || nb !== 0) begin
         errors++; $display("FAIL midrst_abandon: got done=%0d busy cycles=%0d, expected 0 0", nd, nb);
      end
      start0(8'h3C, 8'hC3, 3'd0, 8'hC3);
      wait_done0(4'b1110, 0, "midrst_after");
   endtask

`ifdef SPI_MASTER_LOOPBACK_EN
   task automatic test_loopback;
      lb0 = 1'b1;
      start0(8'hC3, 8'h00, 3'd0, 8'hC3);
      lb0 = 1'b0;
      wait_done0(4'b1111, 0, "loopback");
   endtask
`endif

   initial begin
      test_reset;
      test_mode0;
      test_mode3;
      test_ss_select;
      test_ignore;
      test_back_to_back;
      test_reset_mid;
`ifdef SPI_MASTER_LOOPBACK_EN
      test_loopback;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
